// File: rtl/compute_exp_if.sv
// Request/response bundle for the exponential unit: start/arg in, result/busy/done/ovf out.
interface compute_exp_if #(
  parameter int width = 32
);
  logic             start;
  logic [width-1:0] arg;
  logic [width-1:0] result;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (output start, arg, input result, busy, done, ovf);
  modport slave  (input start, arg, output result, busy, done, ovf);
endinterface

// File: rtl/compute_exp.sv
// exp(arg) in signed Q8.24: ln2 range reduction, 18-step hyperbolic CORDIC
// rotation, then a power-of-two scale with saturation.
module compute_exp #(
  parameter int width = 32
) (
  input  logic         clk,
  input  logic         reset,
  compute_exp_if.slave bus
);
  typedef logic signed [width-1:0] word_t;
  typedef enum logic [1:0] {IDLE, REDUCE, ROTATE, SCALE} state_t;

  localparam word_t LN2     = word_t'(11629080);
  localparam word_t KINV    = word_t'(20258439);
  localparam word_t MAX_POS = {1'b0, {(width-1){1'b1}}};
  localparam logic signed [width+7:0] SAT_LIM = {9'b0, {(width-1){1'b1}}};
  localparam logic signed [5:0] K_MAX = 6'sd7;
  localparam logic signed [5:0] K_MIN = -6'sd25;

  // Iteration index 0..17 maps to shifts 1,2,3,4,4,5..13,13,14,15,16.
  function automatic logic [4:0] shift_of(input logic [4:0] idx);
    if (idx < 5'd4)       shift_of = idx + 5'd1;
    else if (idx < 5'd14) shift_of = idx;
    else                  shift_of = idx - 5'd1;
  endfunction

  function automatic word_t atanh_lut(input logic [4:0] sh);
    case (sh)
      5'd1:    atanh_lut = word_t'(9215828);
      5'd2:    atanh_lut = word_t'(4285116);
      5'd3:    atanh_lut = word_t'(2108178);
      5'd4:    atanh_lut = word_t'(1049944);
      5'd5:    atanh_lut = word_t'(524459);
      5'd6:    atanh_lut = word_t'(262165);
      5'd7:    atanh_lut = word_t'(131075);
      5'd8:    atanh_lut = word_t'(65536);
      5'd9:    atanh_lut = word_t'(32768);
      5'd10:   atanh_lut = word_t'(16384);
      5'd11:   atanh_lut = word_t'(8192);
      5'd12:   atanh_lut = word_t'(4096);
      5'd13:   atanh_lut = word_t'(2048);
      5'd14:   atanh_lut = word_t'(1024);
      5'd15:   atanh_lut = word_t'(512);
      default: atanh_lut = word_t'(256);
    endcase
  endfunction

  state_t            state_q, state_d;
  word_t             r_q, r_d;
  logic signed [5:0] k_q, k_d;
  word_t             x_q, x_d;
  word_t             y_q, y_d;
  word_t             z_q, z_d;
  logic [4:0]        iter_q, iter_d;
  word_t             result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [4:0]               shift;
  word_t                    x_sh, y_sh, angle, s;
  logic [5:0]               k_mag;
  logic signed [width+7:0]  s_ext, s_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      r_q      <= '0;
      k_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      k_q      <= k_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    k_d      = k_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    iter_d   = iter_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    shift = shift_of(iter_q);
    x_sh  = x_q >>> shift;
    y_sh  = y_q >>> shift;
    angle = atanh_lut(shift);
    // x + y = cosh(r) + sinh(r) = e^r once the rotation has converged.
    s     = x_q + y_q;
    k_mag = k_q[5] ? unsigned'(-k_q) : unsigned'(k_q);
    s_ext = {{8{s[width-1]}}, s};
    s_up  = s_ext <<< k_mag;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          r_d     = bus.arg;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (r_q[width-1]) begin
          r_d = r_q + LN2;
          k_d = k_q - 6'sd1;
        end else if (r_q >= LN2) begin
          r_d = r_q - LN2;
          k_d = k_q + 6'sd1;
        end else begin
          x_d     = KINV;
          y_d     = '0;
          z_d     = r_q;
          iter_d  = '0;
          state_d = ROTATE;
        end
        // Exponents outside 2^-24..2^7 are resolved without rotating.
        if (k_d == K_MAX) begin
          result_d = MAX_POS;
          ovf_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (k_d == K_MIN) begin
          result_d = '0;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      ROTATE: begin
        if (!z_q[width-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - angle;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + angle;
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd17) state_d = SCALE;
      end
      SCALE: begin
        if (!k_q[5]) begin
          if (s_up > SAT_LIM) begin
            result_d = MAX_POS;
            ovf_d    = 1'b1;
          end else begin
            result_d = s_up[width-1:0];
            ovf_d    = 1'b0;
          end
        end else begin
          result_d = s >>> k_mag;
          ovf_d    = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_compute_exp.sv
// Bench for compute_exp: directed corner cases, handshake/reset checks and random
// operands compared against a real-valued exp() model with the latency rule.
module tb_compute_exp;
  localparam int LN2 = 11629080;
  localparam int ONE = 16777216;

  logic clk = 1'b0;
  logic reset;
  int   cycle = 0;
  int   accept_cycle = 0;
  int   tests_run = 0;
  int   fail_count = 0;

  compute_exp_if #(.width(32)) bus ();
  compute_exp #(.width(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_tol(input string tag, input logic [31:0] obs, input real expv);
    real err;
    real tol;
    bit  ok;
    err = $itor($signed(obs)) - expv;
    if (err < 0.0) err = -err;
    tol = expv / 16384.0 + 4.0;
    ok  = (err <= tol);
    tests_run++;
    assert (ok === 1'b1) else begin
      fail_count++;
      $error("[TB] FAIL %s: got %0d expected %0d (tolerance %0d)", tag, $signed(obs), $rtoi(expv), $rtoi(tol));
    end
  endtask

  // kind: 0 = normal, 1 = saturated, 2 = underflow to zero.
  task automatic model(input int a, output int lat, output int kind, output real val);
    int n;
    val  = 0.0;
    kind = 0;
    lat  = 0;
    if (a >= 7 * LN2) begin
      kind = 1;
      lat  = 7;
    end else if (a < -24 * LN2) begin
      kind = 2;
      lat  = 25;
    end else begin
      if (a >= 0) n = a / LN2;
      else        n = (-a + LN2 - 1) / LN2;
      lat = 20 + n;
      val = $exp($itor(a) / 16777216.0) * 16777216.0;
    end
  endtask

  task automatic apply_stimulus(input int a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.arg   = a;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    accept_cycle = cycle;
  endtask

  task automatic wait_done(output int lat, output bit seen);
    seen = 1'b0;
    lat  = -1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        lat  = cycle - accept_cycle;
      end
    end
  endtask

  task automatic check_output(input string tag, input int kind, input real val);
    check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(kind == 1));
    if (kind == 1)      check_eq({tag, "_res"}, bus.result, 32'h7FFF_FFFF);
    else if (kind == 2) check_eq({tag, "_res"}, bus.result, 32'd0);
    else                check_tol({tag, "_res"}, bus.result, val);
  endtask

  task automatic run_op(input string tag, input int a);
    int  exp_lat;
    int  kind;
    int  lat;
    real val;
    bit  seen;
    model(a, exp_lat, kind, val);
    apply_stimulus(a);
    @(negedge clk);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat, seen);
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check_output(tag, kind, val);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int  a;
    int  lat;
    bit  seen;
    int  done_count;
    real v;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.arg   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_result", bus.result, 32'd0);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    check_eq("reset_done", 32'(bus.done), 32'd0);
    check_eq("reset_ovf", 32'(bus.ovf), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("zero", 0);
    run_op("one", ONE);
    run_op("minus_one", -ONE);
    run_op("four", 4 * ONE);
    run_op("five_sat", 5 * ONE);
    run_op("minus_twenty", -20 * ONE);
    run_op("ln2", LN2);
    run_op("ln2_m1", LN2 - 1);
    run_op("sat_edge", 7 * LN2);
    run_op("unf_edge", -24 * LN2);
    run_op("unf_edge_m1", -24 * LN2 - 1);
    run_op("max_pos", 32'sh7FFF_FFFF);
    run_op("max_neg", 32'sh8000_0000);

    // start held through a saturating op: ignored on the done edge, accepted next cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.arg   = 5 * ONE;
    @(posedge clk);
    #1;
    accept_cycle = cycle;
    bus.arg      = 0;
    wait_done(lat, seen);
    check_eq("b2b_first_lat", lat, 32'd7);
    check_output("b2b_first", 1, 0.0);
    check_eq("b2b_idle_gap_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    accept_cycle = cycle;
    @(negedge clk);
    check_eq("b2b_second_busy", 32'(bus.busy), 32'd1);
    wait_done(lat, seen);
    check_eq("b2b_second_lat", lat, 32'd20);
    check_output("b2b_second", 0, 16777216.0);

    // start pulse mid-rotation must not disturb the operation in flight
    apply_stimulus(ONE);
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.arg   = -5 * ONE;
    @(negedge clk);
    bus.start = 1'b0;
    bus.arg   = '0;
    wait_done(lat, seen);
    check_eq("midstart_lat", lat, 32'd21);
    v = $exp(1.0) * 16777216.0;
    check_output("midstart", 0, v);

    // reset mid-rotation aborts with no done pulse
    apply_stimulus(4 * ONE);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_result", bus.result, 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    done_count = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_count++;
    end
    check_eq("abort_no_done", done_count, 32'd0);
    run_op("after_reset", -ONE);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(34 * LN2, 0)) - 26 * LN2;
      if (a >= 7 * LN2 - (1 << 21) && a < 7 * LN2) a = a - (1 << 22);
      run_op($sformatf("rand%0d", i), a);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end
endmodule
